// File: rtl/intc_vectored_pkg.sv
// Shared definitions for the vectored interrupt controller: register offsets,
// handshake FSM encoding and register reset values.
package intc_vectored_pkg;

  localparam logic [1:0] INTC_REG_PENDING  = 2'd0;
  localparam logic [1:0] INTC_REG_MASK     = 2'd1;
  localparam logic [1:0] INTC_REG_EDGE_SEL = 2'd2;
  localparam logic [1:0] INTC_REG_STATUS   = 2'd3;

  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_ACKD = 2'd2
  } intc_state_e;

  // Every source starts out edge-triggered.
  localparam logic [15:0] INTC_EDGE_SEL_RST = 16'hFFFF;

  function automatic logic [31:0] intc_status(input logic ackd, input logic req,
                                              input logic [3:0] id);
    return {23'b0, ackd, req, 3'b0, id};
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Find-first-set over N_SRC request bits, searching upward from a start index
// and wrapping; start is 0 for fixed priority.
module intc_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  int idx;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(start) + k) % N_SRC;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/intc_vectored.sv
// Multi-source interrupt controller driving the CPU Ireq/Iack handshake.
// Define INTC_PRIO_ROTATE_EN for round-robin priority; otherwise lowest index wins.
module intc_vectored
  import intc_vectored_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk_CPU,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  output logic             Ireq,
  input  logic             Iack,
  output logic [ID_W-1:0]  irq_id,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata
);

  localparam int ID_PAD = (ID_W < 4) ? ID_W : 4;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] hist_q;
  logic [N_SRC-1:0] synced;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] edge_sel_q;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] w1c_vec;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  irq_id_q;
  logic [ID_W-1:0]  start_idx;
  logic [ID_W-1:0]  enc_id;
  logic             enc_valid;
  logic             ack_fire;
  logic             load_id;
  logic [3:0]       id4;
  logic             wdata_unused;
  intc_state_e      state_q, state_d;

  assign wdata_unused = ^reg_wdata[31:N_SRC];

  // Synchroniser chain plus one history flop for rising-edge detection.
  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign set_vec  = (synced & ~hist_q & edge_sel_q) | (synced & ~edge_sel_q);
  assign w1c_vec  = (reg_we && reg_addr == INTC_REG_PENDING) ? reg_wdata[N_SRC-1:0] : '0;
  assign ack_fire = (state_q == INTC_REQ) && Iack;

  // Level-mode sources are not cleared by the acknowledge; the ISR quiets them.
  always_comb begin
    ack_clr = '0;
    if (ack_fire && edge_sel_q[irq_id_q]) ack_clr[irq_id_q] = 1'b1;
  end

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= INTC_EDGE_SEL_RST[N_SRC-1:0];
    end else begin
      pending_q <= (pending_q & ~w1c_vec & ~ack_clr) | set_vec;
      if (reg_we && reg_addr == INTC_REG_MASK)     mask_q     <= reg_wdata[N_SRC-1:0];
      if (reg_we && reg_addr == INTC_REG_EDGE_SEL) edge_sel_q <= reg_wdata[N_SRC-1:0];
    end
  end

  assign eligible = pending_q & mask_q;

`ifdef INTC_PRIO_ROTATE_EN
  logic [ID_W-1:0] rot_ptr_q;

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      rot_ptr_q <= '0;
    end else if (ack_fire) begin
      rot_ptr_q <= (irq_id_q == ID_W'(N_SRC - 1)) ? '0 : irq_id_q + 1'b1;
    end
  end

  assign start_idx = rot_ptr_q;
`else
  assign start_idx = '0;
`endif

  intc_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (eligible),
    .start (start_idx),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      state_q  <= INTC_IDLE;
      irq_id_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_id) irq_id_q <= enc_id;
    end
  end

  // A request, once raised, is held until the CPU acknowledges it.
  always_comb begin
    state_d = state_q;
    load_id = 1'b0;
    case (state_q)
      INTC_IDLE: begin
        if (enc_valid) begin
          state_d = INTC_REQ;
          load_id = 1'b1;
        end
      end
      INTC_REQ: begin
        if (Iack) state_d = INTC_ACKD;
      end
      INTC_ACKD: begin
        if (!Iack) state_d = INTC_IDLE;
      end
      default: state_d = INTC_IDLE;
    endcase
  end

  assign Ireq   = (state_q == INTC_REQ);
  assign irq_id = irq_id_q;

  always_comb begin
    id4 = '0;
    id4[ID_PAD-1:0] = irq_id_q[ID_PAD-1:0];
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      INTC_REG_PENDING:  reg_rdata[N_SRC-1:0] = pending_q;
      INTC_REG_MASK:     reg_rdata[N_SRC-1:0] = mask_q;
      INTC_REG_EDGE_SEL: reg_rdata[N_SRC-1:0] = edge_sel_q;
      default: reg_rdata = intc_status(state_q == INTC_ACKD, state_q == INTC_REQ, id4);
    endcase
  end

endmodule

// File: tb/tb_intc_vectored.sv
// Bench for intc_vectored: directed scenarios with literal expectations, then
// randomized sources, register traffic and CPU acknowledges against a behavioural model.
module tb_intc_vectored;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int S    = 2;

  logic            Clk_CPU = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    irq_src = '0;
  logic            Iack = 1'b0;
  logic            reg_we = 1'b0;
  logic [1:0]      reg_addr = 2'd0;
  logic [31:0]     reg_wdata = '0;
  logic            Ireq;
  logic [ID_W-1:0] irq_id;
  logic [31:0]     reg_rdata;

  intc_vectored #(.N_SRC(N), .ID_W(ID_W), .SYNC_STAGES(S)) dut (
    .Clk_CPU   (Clk_CPU),
    .rst       (rst),
    .irq_src   (irq_src),
    .Ireq      (Ireq),
    .Iack      (Iack),
    .irq_id    (irq_id),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  // ---------------- clock ----------------
  always #5 Clk_CPU = ~Clk_CPU;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend, m_mask, m_esel;
  logic [N-1:0] hq[$];
  bit           m_req, m_ackd;
  int           m_id, m_ptr;
  logic [N-1:0] mv_set, mv_clr, mv_elig, mv_now, mv_prev;
  int           mv_pick, mv_start;

  function automatic int pick(input logic [N-1:0] elig, input int start);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (start + k) % N;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0: return 32'(m_pend);
      2'd1: return 32'(m_mask);
      2'd2: return 32'(m_esel);
      default: return {23'b0, m_ackd, m_req, 3'b0, 4'(m_id)};
    endcase
  endfunction

  always @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_mask = '0; m_esel = '1;
      m_req = 1'b0; m_ackd = 1'b0; m_id = 0; m_ptr = 0;
      hq.delete();
      for (int k = 0; k <= S; k++) hq.push_back('0);
    end else begin
      // hq[0] is the sample taken at the last edge; a source is seen S edges late.
      mv_now  = hq[S-1];
      mv_prev = hq[S];
      for (int i = 0; i < N; i++)
        mv_set[i] = m_esel[i] ? (mv_now[i] & ~mv_prev[i]) : mv_now[i];
      mv_clr = '0;
      if (reg_we && reg_addr == 2'd0) mv_clr = reg_wdata[N-1:0];
      if (m_req && Iack && m_esel[m_id]) mv_clr[m_id] = 1'b1;
      mv_elig = m_pend & m_mask;
`ifdef INTC_PRIO_ROTATE_EN
      mv_start = m_ptr;
`else
      mv_start = 0;
`endif
      if (!m_req && !m_ackd) begin
        mv_pick = pick(mv_elig, mv_start);
        if (mv_pick >= 0) begin
          m_req = 1'b1;
          m_id  = mv_pick;
        end
      end else if (m_req) begin
        if (Iack) begin
          m_req  = 1'b0;
          m_ackd = 1'b1;
          m_ptr  = (m_id + 1) % N;
        end
      end else if (!Iack) begin
        m_ackd = 1'b0;
      end
      m_pend = (m_pend & ~mv_clr) | mv_set;
      if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[N-1:0];
      if (reg_we && reg_addr == 2'd2) m_esel = reg_wdata[N-1:0];
      hq.push_front(irq_src);
      void'(hq.pop_back());
    end
  end

  // Compare process: outputs are settled on the falling edge.
  always @(negedge Clk_CPU) begin
    if (chk_en) begin
      check("model_ireq", 32'(Ireq), 32'(m_req));
      check("model_irq_id", 32'(irq_id), 32'(m_id));
      check("model_rdata", reg_rdata, m_rdata(reg_addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge Clk_CPU);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cycle();
    reg_we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(name, reg_rdata, exp);
  endtask

  task automatic wait_ireq(input string name, output int edges);
    edges = 0;
    while (Ireq !== 1'b1 && edges < 20) begin
      @(posedge Clk_CPU);
      #1;
      edges++;
    end
    check(name, 32'(Ireq), 32'd1);
    cycle();
  endtask

  task automatic ack(input string name);
    int n;
    n = 0;
    Iack = 1'b1;
    while (Ireq !== 1'b0 && n < 10) begin
      cycle();
      n++;
    end
    check(name, 32'(Ireq), 32'd0);
    Iack = 1'b0;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e;
    repeat (2) cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    // Reset state
    check("rst_ireq", 32'(Ireq), 32'd0);
    read_check("rst_pending", 2'd0, 32'h0);
    read_check("rst_mask", 2'd1, 32'h0);
    read_check("rst_edge_sel", 2'd2, 32'hF);
    read_check("rst_status", 2'd3, 32'h0);

    // Edge-mode source 0: four-edge latency, ack clears, no repeat
    reg_write(2'd1, 32'h1);
    irq_src[0] = 1'b1;
    wait_ireq("edge_req", e);
    check("edge_latency", 32'(e), 32'd4);
    check("edge_id", 32'(irq_id), 32'd0);
    read_check("edge_status_req", 2'd3, 32'h80);
    Iack = 1'b1;
    @(posedge Clk_CPU);
    #1;
    check("edge_ack_drop", 32'(Ireq), 32'd0);
    cycle();
    read_check("edge_pend_cleared", 2'd0, 32'h0);
    read_check("edge_status_ackd", 2'd3, 32'h100);
    Iack = 1'b0;
    repeat (6) cycle();
    check("edge_no_repeat", 32'(Ireq), 32'd0);
    irq_src[0] = 1'b0;
    repeat (3) cycle();

    // Priority: sources 3 and 1 together
    reg_write(2'd1, 32'hF);
    irq_src = 4'b1010;
    wait_ireq("prio_req1", e);
    check("prio_first_id", 32'(irq_id), 32'd1);
    ack("prio_ack1");
    wait_ireq("prio_req2", e);
    check("prio_second_id", 32'(irq_id), 32'd3);
    read_check("prio_status", 2'd3, 32'h83);
    ack("prio_ack2");
    irq_src = '0;
    repeat (4) cycle();
    check("prio_quiet", 32'(Ireq), 32'd0);

    // Level mode on source 1
    reg_write(2'd2, 32'hD);
    irq_src[1] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_ireq("level_req", e);
      check("level_id", 32'(irq_id), 32'd1);
      ack("level_ack");
    end
    reg_write(2'd0, 32'h2);
    read_check("level_reset", 2'd0, 32'h2);
    irq_src[1] = 1'b0;
    repeat (4) cycle();
    reg_write(2'd0, 32'h2);
    read_check("level_w1c_low", 2'd0, 32'h0);
    ack("level_final_ack");
    repeat (6) cycle();
    check("level_quiet", 32'(Ireq), 32'd0);
    reg_write(2'd2, 32'hF);

    // Collision: W1C in the same cycle as an edge-set
    reg_write(2'd1, 32'h0);
    irq_src[2] = 1'b1;
    cycle();
    cycle();
    read_check("coll_pre", 2'd0, 32'h0);
    reg_write(2'd0, 32'h4);
    read_check("coll_set_wins", 2'd0, 32'h4);
    reg_write(2'd0, 32'h4);
    read_check("coll_w1c", 2'd0, 32'h0);
    irq_src[2] = 1'b0;

    // Masking
    repeat (3) cycle();
    irq_src[2] = 1'b1;
    repeat (5) cycle();
    read_check("mask_pend", 2'd0, 32'h4);
    check("mask_blocked", 32'(Ireq), 32'd0);
    reg_write(2'd1, 32'h4);
    check("mask_one_edge", 32'(Ireq), 32'd0);
    cycle();
    check("mask_two_edges", 32'(Ireq), 32'd1);
    check("mask_id", 32'(irq_id), 32'd2);
    reg_write(2'd1, 32'h0);
    repeat (3) cycle();
    check("mask_held", 32'(Ireq), 32'd1);
    check("mask_held_id", 32'(irq_id), 32'd2);
    ack("mask_ack");
    irq_src[2] = 1'b0;

    // Reset in the middle of a request
    reg_write(2'd1, 32'h1);
    irq_src[0] = 1'b1;
    wait_ireq("rst_mid_req", e);
    rst = 1'b1;
    #1;
    check("rst_async_drop", 32'(Ireq), 32'd0);
    irq_src = '0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    read_check("rst2_pending", 2'd0, 32'h0);
    read_check("rst2_mask", 2'd1, 32'h0);
    read_check("rst2_status", 2'd3, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) irq_src[i] = ~irq_src[i];
      reg_we    = ($urandom_range(0, 7) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      if (!Iack && Ireq && $urandom_range(0, 3) == 0) Iack = 1'b1;
      else if (Iack && !Ireq && $urandom_range(0, 2) == 0) Iack = 1'b0;
      else if (!Iack && !Ireq && $urandom_range(0, 63) == 0) Iack = 1'b1;
      cycle();
    end
    reg_we = 1'b0;
    Iack = 1'b0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
